morph_nxn: RTL and testbench

- Streaming binary morphology filter for a 1-bit skin/foreground mask travelling alongside HDMI-style timing (de/hsync/vsync).
- Generalises the fixed 3x3 dilation stage to an odd KSIZE x KSIZE square kernel.
- Dilation or erosion is selectable at runtime, latched per frame.
- Sits between the mask threshold stage and the mask-to-RGB/overlay stage; one pixel per enabled clock.

---
 rtl/morph_nxn_if.sv | 22 ++
 rtl/morph_nxn.sv | 161 ++++++++++++++++
 tb/tb_morph_nxn.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/morph_nxn_if.sv
// Pixel-stream bundle for morph_nxn: mask plus HDMI-style timing in, filtered
// mask plus delayed timing out.
interface morph_nxn_if;
    logic mask;
    logic in_de;
    logic in_hsync;
    logic in_vsync;
    logic result;
    logic out_de;
    logic out_hsync;
    logic out_vsync;

    modport master (
        output mask, in_de, in_hsync, in_vsync,
        input  result, out_de, out_hsync, out_vsync
    );

    modport slave (
        input  mask, in_de, in_hsync, in_vsync,
        output result, out_de, out_hsync, out_vsync
    );
endinterface

// File: rtl/morph_nxn.sv
// Streaming KSIZE x KSIZE binary dilation/erosion of a 1-bit mask with timing pass-through.
// Optional set-pixel frame counter enabled by defining MORPH_PIXCOUNT_EN.
module morph_nxn #(
    parameter logic [9:0] H_SIZE = 10'd83,
    parameter int         KSIZE  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        op,
    morph_nxn_if.slave  px,
    output logic [23:0] pix_count
);
    localparam int R  = KSIZE / 2;
    localparam int H  = int'(H_SIZE);
    localparam int L  = R * H + R + 1;
    localparam int NB = 2 * R;
    localparam int D  = L - 1;
    localparam int PW = (H > 1) ? $clog2(H) : 1;
    localparam int DW = (D > 1) ? $clog2(D) : 1;
    localparam int FW = $clog2(L + 1);

    logic          op_q;
    logic          vs_q;
    logic [PW-1:0] lb_ptr_q, lb_ptr_d;
    logic [DW-1:0] sd_ptr_q, sd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          valid_d;

    logic             lb_mem [NB][H];
    logic [2:0]       sd_mem [D];
    logic [KSIZE-1:1] win_q  [KSIZE];

    logic [KSIZE-1:0] col;
    logic             pix;
    logic             any_set, all_set;
    logic [2:0]       sync_rd;

    logic result_q, result_d;
    logic out_de_q, out_de_d;
    logic out_hs_q, out_hs_d;
    logic out_vs_q, out_vs_d;

    // Blanking is fed in as the neutral element so frame edges stay untouched.
    assign pix     = px.in_de ? px.mask : op_q;
    assign sync_rd = sd_mem[sd_ptr_q];

    always_comb begin
        col    = '0;
        col[0] = pix;
        for (int r = 1; r < KSIZE; r++) begin
            col[r] = lb_mem[r-1][lb_ptr_q];
        end
    end

    // The newest column is taken straight from the line-buffer taps, which
    // saves one cycle and keeps the centre tap R*H+R cycles behind the input.
    always_comb begin
        any_set = 1'b0;
        all_set = 1'b1;
        for (int r = 0; r < KSIZE; r++) begin
            any_set = any_set | col[r] | (|win_q[r]);
            all_set = all_set & col[r] & (&win_q[r]);
        end
    end

    always_comb begin
        lb_ptr_d = (lb_ptr_q == PW'(H - 1)) ? '0 : lb_ptr_q + PW'(1);
        sd_ptr_d = (sd_ptr_q == DW'(D - 1)) ? '0 : sd_ptr_q + DW'(1);
        fill_d   = (fill_q == FW'(L)) ? fill_q : fill_q + FW'(1);
        valid_d  = (fill_d == FW'(L));
        out_de_d = valid_d & sync_rd[2];
        out_hs_d = valid_d & sync_rd[1];
        out_vs_d = valid_d & sync_rd[0];
        result_d = valid_d & sync_rd[2] & (op_q ? all_set : any_set);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 1'b0;
            vs_q     <= 1'b0;
            lb_ptr_q <= '0;
            sd_ptr_q <= '0;
            fill_q   <= '0;
            result_q <= 1'b0;
            out_de_q <= 1'b0;
            out_hs_q <= 1'b0;
            out_vs_q <= 1'b0;
        end else if (ce) begin
            vs_q <= px.in_vsync;
            if (px.in_vsync && !vs_q) begin
                op_q <= op;
            end
            lb_ptr_q <= lb_ptr_d;
            sd_ptr_q <= sd_ptr_d;
            fill_q   <= fill_d;
            result_q <= result_d;
            out_de_q <= out_de_d;
            out_hs_q <= out_hs_d;
            out_vs_q <= out_vs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            for (int r = 0; r < NB; r++) begin
                lb_mem[r][lb_ptr_q] <= col[r];
            end
            sd_mem[sd_ptr_q] <= {px.in_de, px.in_hsync, px.in_vsync};
            for (int r = 0; r < KSIZE; r++) begin
                win_q[r][1] <= col[r];
                for (int c = 2; c < KSIZE; c++) begin
                    win_q[r][c] <= win_q[r][c-1];
                end
            end
        end
    end

    assign px.result    = result_q;
    assign px.out_de    = out_de_q;
    assign px.out_hsync = out_hs_q;
    assign px.out_vsync = out_vs_q;

`ifdef MORPH_PIXCOUNT_EN
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] pix_q, pix_d;
    logic        ovs_q;
    logic        ovs_rise;
    logic        inc;

    // On a frame boundary the snapshot takes the pre-increment value.
    always_comb begin
        ovs_rise = out_vs_q & ~ovs_q;
        inc      = out_de_q & result_q;
        cnt_d    = cnt_q;
        pix_d    = pix_q;
        if (ovs_rise) begin
            pix_d = cnt_q;
            cnt_d = {23'd0, inc};
        end else if (inc && (cnt_q != 24'hFFFFFF)) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pix_q <= '0;
            ovs_q <= 1'b0;
        end else if (ce) begin
            cnt_q <= cnt_d;
            pix_q <= pix_d;
            ovs_q <= out_vs_q;
        end
    end

    assign pix_count = pix_q;
`else
    assign pix_count = '0;
`endif
endmodule

// File: tb/tb_morph_nxn.sv
// Self-checking bench for morph_nxn: table of frame vectors, image-level model, output scoreboard.
module tb_morph_nxn;
    localparam logic [9:0] HSZ = 10'd16;
    localparam int K  = 3;
    localparam int H  = 16;
    localparam int L  = 18;
    localparam int AW = 10;
    localparam int AH = 10;
    localparam int VB = 3;
`ifdef MORPH_PIXCOUNT_EN
    localparam int EXP_PC = 9;
`else
    localparam int EXP_PC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic        op = 1'b0;
    logic [23:0] pix_count;

    morph_nxn_if px ();

    morph_nxn #(.H_SIZE(HSZ), .KSIZE(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .op        (op),
        .px        (px),
        .pix_count (pix_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic res;
    } rec_t;

    typedef struct {
        int pat;
        bit op;
        bit op_mid;
        int exp_set;
    } vec_t;

    vec_t        vecs [9];
    rec_t        sb [$];
    int          cnt_q [$];
    rec_t        last_exp;
    logic [AW-1:0] img [AH];
    int          acc;
    logic        prev_exp_vs;
    logic        m_vs_prev;
    logic        m_op;
    bit          rand_ce;
    int          errors;
    int          checks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference morphology on the whole frame; outside the active area is ignored.
    function automatic logic exp_pix(input int r, input int c);
        logic a;
        int rr, cc;
        a = m_op;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if (rr >= 0 && rr < AH && cc >= 0 && cc < AW) begin
                    if (m_op) a = a & img[rr][cc];
                    else      a = a | img[rr][cc];
                end
            end
        end
        return a;
    endfunction

    task automatic tick(input rec_t in_rec);
        rec_t e;
        int   x;
        @(posedge clk);
        #1;
        if (ce) begin
            sb.push_back(in_rec);
            e = '0;
            if (sb.size() >= L) e = sb.pop_front();
            chk("outputs", {28'd0, px.out_de, px.out_hsync, px.out_vsync, px.result},
                {28'd0, e.de, e.hs, e.vs, e.res});
            if (e.de && px.result) acc++;
            if (e.vs && !prev_exp_vs) begin
                if (cnt_q.size() > 0) begin
                    x = cnt_q.pop_front();
                    if (x >= 0) chk("frame_set_count", acc, x);
                end
                acc = 0;
            end
            prev_exp_vs = e.vs;
            last_exp = e;
        end else begin
            chk("hold_ce0", {28'd0, px.out_de, px.out_hsync, px.out_vsync, px.result},
                {28'd0, last_exp.de, last_exp.hs, last_exp.vs, last_exp.res});
        end
    endtask

    task automatic drive_px(input logic de, input logic hs, input logic vs, input logic m,
                            input logic res);
        rec_t r;
        bit   done;
        r.de = de; r.hs = hs; r.vs = vs; r.res = res;
        px.in_de = de; px.in_hsync = hs; px.in_vsync = vs; px.mask = m;
        done = 1'b0;
        while (!done) begin
            ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
            tick(r);
            done = ce;
        end
        if (vs && !m_vs_prev) m_op = op;
        m_vs_prev = vs;
    endtask

    task automatic drive_line(input int row, input logic vs);
        logic de, hs, m, res;
        for (int c = 0; c < H; c++) begin
            de  = (row >= 0) && (c < AW);
            hs  = (c == 11) || (c == 12);
            m   = 1'($urandom_range(0, 1));
            res = 1'b0;
            if (de) begin
                m   = img[row][c];
                res = exp_pix(row, c);
            end
            drive_px(de, hs, vs, m, res);
        end
    endtask

    task automatic load_img(input int pat);
        for (int r = 0; r < AH; r++) begin
            for (int c = 0; c < AW; c++) begin
                case (pat)
                    0:       img[r][c] = (r == 4) && (c == 5);
                    1:       img[r][c] = 1'b1;
                    2:       img[r][c] = (r >= 2) && (r <= 5) && (c >= 2) && (c <= 5);
                    default: img[r][c] = ($urandom_range(0, 3) != 0);
                endcase
            end
        end
    endtask

    task automatic drive_frame(input vec_t v, input int nlines);
        load_img(v.pat);
        op = v.op;
        for (int l = 0; l < nlines; l++) begin
            if (l == VB + 5) op = v.op_mid;
            drive_line((l >= VB) ? l - VB : -1, (l == 1) || (l == 2));
        end
        if (nlines == VB + AH) cnt_q.push_back(v.exp_set);
    endtask

    task automatic drive_tail();
        for (int l = 0; l < 5; l++) drive_line(-1, (l == 1) || (l == 2));
    endtask

    task automatic clear_model();
        sb.delete();
        cnt_q.delete();
        acc = 0;
        prev_exp_vs = 1'b0;
        m_vs_prev = 1'b0;
        m_op = 1'b0;
        last_exp = '0;
    endtask

    initial begin
        vecs[0] = '{pat: 0, op: 1'b0, op_mid: 1'b0, exp_set: 9};
        vecs[1] = '{pat: 0, op: 1'b1, op_mid: 1'b1, exp_set: 0};
        vecs[2] = '{pat: 1, op: 1'b1, op_mid: 1'b1, exp_set: 100};
        vecs[3] = '{pat: 1, op: 1'b0, op_mid: 1'b0, exp_set: 100};
        vecs[4] = '{pat: 2, op: 1'b1, op_mid: 1'b1, exp_set: 4};
        vecs[5] = '{pat: 2, op: 1'b0, op_mid: 1'b1, exp_set: 36};
        vecs[6] = '{pat: 2, op: 1'b1, op_mid: 1'b1, exp_set: 4};
        vecs[7] = '{pat: 3, op: 1'b0, op_mid: 1'b0, exp_set: -1};
        vecs[8] = '{pat: 3, op: 1'b1, op_mid: 1'b1, exp_set: -1};

        errors = 0;
        checks = 0;
        rand_ce = 1'b0;
        px.mask = 1'b0; px.in_de = 1'b0; px.in_hsync = 1'b0; px.in_vsync = 1'b0;
        clear_model();

        #1;
        chk("reset_outputs", {28'd0, px.out_de, px.out_hsync, px.out_vsync, px.result}, 32'd0);
        chk("reset_pix_count", {8'd0, pix_count}, 32'd0);
        #21 rst_n = 1'b1;

        for (int pass = 0; pass < 2; pass++) begin
            rand_ce = (pass == 1);
            for (int i = 0; i < 9; i++) drive_frame(vecs[i], VB + AH);
        end

        rand_ce = 1'b0;
        drive_frame(vecs[2], 7);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {28'd0, px.out_de, px.out_hsync, px.out_vsync, px.result}, 32'd0);
        chk("async_reset_pix_count", {8'd0, pix_count}, 32'd0);
        clear_model();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        drive_frame(vecs[0], VB + AH);
        drive_tail();
        chk("pix_count", {8'd0, pix_count}, EXP_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
